// File: rtl/stage_id.sv
// stage_id: RV32I decode stage with register file, immediate generation and load-use hazard detection
module stage_id #(
  parameter int DATA_DBUS_WIDTH = 32,
  parameter int ADDR_IBUS_WIDTH = 32,
  parameter int DATA_IBUS_WIDTH = 32
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [DATA_IBUS_WIDTH-1:0] i_Inst,
  input  logic [ADDR_IBUS_WIDTH-1:0] i_PC,
  input  logic                       i_Stall,
  input  logic                       i_Flush,
  input  logic                       i_RegWrEnable,
  input  logic [4:0]                 i_RegWrAddr,
  input  logic [DATA_DBUS_WIDTH-1:0] i_RegWrData,
  output logic                       o_StallReq,
  output logic                       o_Valid,
  output logic [ADDR_IBUS_WIDTH-1:0] o_PC,
  output logic [DATA_DBUS_WIDTH-1:0] o_DataA,
  output logic [DATA_DBUS_WIDTH-1:0] o_DataB,
  output logic [31:0]                o_Imm,
  output logic [4:0]                 o_RegWrAddr,
  output logic                       o_RegWrEnable,
  output logic [3:0]                 o_AluOp,
  output logic                       o_OperandASel,
  output logic                       o_OperandBSel,
  output logic                       o_MemRdEnable,
  output logic                       o_MemWrEnable,
  output logic                       o_IsBranch,
  output logic                       o_IsJump,
  output logic [2:0]                 o_Funct3,
  output logic                       o_IllegalInst
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam int OW = ADDR_IBUS_WIDTH + 2 * DATA_DBUS_WIDTH + 53;

  logic [DATA_DBUS_WIDTH-1:0] rf_q [32];
  logic [6:0]                 opcode;
  logic [4:0]                 rs1;
  logic [4:0]                 rs2;
  logic [2:0]                 funct3;
  logic                       alt;
  logic [DATA_DBUS_WIDTH-1:0] rs1_val;
  logic [DATA_DBUS_WIDTH-1:0] rs2_val;
  logic [31:0]                imm_i;
  logic [31:0]                imm_s;
  logic [31:0]                imm_b;
  logic [31:0]                imm_u;
  logic [31:0]                imm_j;
  logic [3:0]                 alu_f3;
  logic [31:0]                dec_imm;
  logic [3:0]                 dec_alu;
  logic                       dec_asel;
  logic                       dec_bsel;
  logic                       dec_we;
  logic                       dec_mrd;
  logic                       dec_mwr;
  logic                       dec_br;
  logic                       dec_jmp;
  logic                       dec_ill;
  logic                       use_rs1;
  logic                       use_rs2;
  logic                       bubble;
  logic [OW-1:0]              out_d;
  logic [OW-1:0]              out_q;

  assign opcode = i_Inst[6:0];
  assign rs1    = i_Inst[19:15];
  assign rs2    = i_Inst[24:20];
  assign funct3 = i_Inst[14:12];
  assign alt    = i_Inst[30];

  // x0 is hardwired; a same-cycle write-back is forwarded so decode never sees stale data
  assign rs1_val = (rs1 == 5'd0) ? '0 :
                   (i_RegWrEnable && i_RegWrAddr == rs1) ? i_RegWrData : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 :
                   (i_RegWrEnable && i_RegWrAddr == rs2) ? i_RegWrData : rf_q[rs2];

  assign imm_i = {{20{i_Inst[31]}}, i_Inst[31:20]};
  assign imm_s = {{20{i_Inst[31]}}, i_Inst[31:25], i_Inst[11:7]};
  assign imm_b = {{19{i_Inst[31]}}, i_Inst[31], i_Inst[7], i_Inst[30:25], i_Inst[11:8], 1'b0};
  assign imm_u = {i_Inst[31:12], 12'h000};
  assign imm_j = {{11{i_Inst[31]}}, i_Inst[31], i_Inst[19:12], i_Inst[20], i_Inst[30:21], 1'b0};

  // Register file update; write-back keeps running through stalls and flushes
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (i_RegWrEnable && i_RegWrAddr != 5'd0) begin
      rf_q[i_RegWrAddr] <= i_RegWrData;
    end
  end

  // funct3 to ALU op; bit30 means SUB only for register-register ops, SRA for right shifts
  always_comb begin
    case (funct3)
      3'b000:  alu_f3 = (alt && opcode == OP_REG) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  // Opcode decode into control fields and source-operand usage
  always_comb begin
    dec_imm  = '0;
    dec_alu  = ALU_ADD;
    dec_asel = 1'b0;
    dec_bsel = 1'b0;
    dec_we   = 1'b0;
    dec_mrd  = 1'b0;
    dec_mwr  = 1'b0;
    dec_br   = 1'b0;
    dec_jmp  = 1'b0;
    dec_ill  = 1'b0;
    use_rs1  = 1'b1;
    use_rs2  = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec_imm  = imm_u;
        dec_alu  = ALU_PASSB;
        dec_bsel = 1'b1;
        dec_we   = 1'b1;
        use_rs1  = 1'b0;
      end
      OP_AUIPC: begin
        dec_imm  = imm_u;
        dec_asel = 1'b1;
        dec_bsel = 1'b1;
        dec_we   = 1'b1;
        use_rs1  = 1'b0;
      end
      OP_JAL: begin
        dec_imm  = imm_j;
        dec_asel = 1'b1;
        dec_jmp  = 1'b1;
        dec_we   = 1'b1;
        use_rs1  = 1'b0;
      end
      OP_JALR: begin
        dec_imm = imm_i;
        dec_jmp = 1'b1;
        dec_we  = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm = imm_b;
        dec_alu = ALU_SUB;
        dec_br  = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_LOAD: begin
        dec_imm  = imm_i;
        dec_bsel = 1'b1;
        dec_mrd  = 1'b1;
        dec_we   = 1'b1;
      end
      OP_STORE: begin
        dec_imm  = imm_s;
        dec_bsel = 1'b1;
        dec_mwr  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_IMM: begin
        dec_imm  = imm_i;
        dec_alu  = alu_f3;
        dec_bsel = 1'b1;
        dec_we   = 1'b1;
      end
      OP_REG: begin
        dec_alu = alu_f3;
        dec_we  = 1'b1;
        use_rs2 = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // A load in the output slot whose rd feeds the instruction now being decoded
  assign o_StallReq = ~i_Flush & o_Valid & o_MemRdEnable & (o_RegWrAddr != 5'd0) &
                      ((use_rs1 & (o_RegWrAddr == rs1)) | (use_rs2 & (o_RegWrAddr == rs2)));

  // The all-zero word is the fetch stage's reset value, so it becomes a bubble rather than illegal
  assign bubble = i_Flush | o_StallReq | (i_Inst == '0);

  assign out_d = bubble ? '0 : {1'b1, i_PC, rs1_val, rs2_val, dec_imm, i_Inst[11:7], dec_we,
                                dec_alu, dec_asel, dec_bsel, dec_mrd, dec_mwr, dec_br, dec_jmp,
                                funct3, dec_ill};

  // Output slot toward execute; a stall freezes every field
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) out_q <= '0;
    else if (!i_Stall) out_q <= out_d;
  end

  assign {o_Valid, o_PC, o_DataA, o_DataB, o_Imm, o_RegWrAddr, o_RegWrEnable, o_AluOp,
          o_OperandASel, o_OperandBSel, o_MemRdEnable, o_MemWrEnable, o_IsBranch, o_IsJump,
          o_Funct3, o_IllegalInst} = out_q;
endmodule
